// File: rtl/m_wb_gpio_pkg.sv
// Shared constants for the Wishbone GPIO block:
// register word addresses, bus width and byte-lane mask helper.
package m_wb_gpio_pkg;

  localparam int DW = 32;

  localparam logic [2:0] A_OUT   = 3'd0;
  localparam logic [2:0] A_SET   = 3'd1;
  localparam logic [2:0] A_CLR   = 3'd2;
  localparam logic [2:0] A_TGL   = 3'd3;
  localparam logic [2:0] A_IN    = 3'd4;
  localparam logic [2:0] A_EDGE  = 3'd5;
  localparam logic [2:0] A_IRQEN = 3'd6;

  function automatic logic [DW-1:0] lane_mask(input logic [3:0] sel);
    logic [DW-1:0] m;
    for (int k = 0; k < 4; k++)
      m[8*k +: 8] = {8{sel[k]}};
    return m;
  endfunction

endpackage

// File: rtl/m_wb_gpio_sync_edge.sv
// Input pin synchroniser chain followed by a one-cycle
// history flop that flags 0->1 transitions of the synchronised value.
module m_sync_edge #(
  parameter int NIN        = 1,
  parameter int SYNCSTAGES = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NIN-1:0] pin_i,
  output logic [NIN-1:0] in_o,
  output logic [NIN-1:0] rise_o
);

  logic [SYNCSTAGES-1:0][NIN-1:0] sync_q;
  logic [NIN-1:0]                 hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNCSTAGES-2:0], pin_i};
      hist_q <= sync_q[SYNCSTAGES-1];
    end
  end

  assign in_o   = sync_q[SYNCSTAGES-1];
  assign rise_o = in_o & ~hist_q;

endmodule

// File: rtl/m_wb_gpio.sv
// Wishbone classic slave GPIO: output register with set/clear/toggle
// aliases, synchronised inputs, sticky rising-edge flags and interrupt.
module m_wb_gpio
  import m_wb_gpio_pkg::*;
#(
  parameter int              NOUT       = 4,
  parameter int              NIN        = 1,
  parameter int              SYNCSTAGES = 2,
  parameter logic [NOUT-1:0] OUTRESET   = '0
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            CYC_I,
  input  logic            STB_I,
  input  logic            WE_I,
  input  logic [2:0]      ADR_I,
  input  logic [3:0]      SEL_I,
  input  logic [DW-1:0]   DAT_I,
  output logic [DW-1:0]   DAT_O,
  output logic            ACK_O,
  input  logic [NIN-1:0]  pin_i,
  output logic [NOUT-1:0] pin_o,
  output logic            irq_o
);

  logic            ack_q;
  logic            irq_q;
  logic [DW-1:0]   dat_q, dat_d;
  logic [NOUT-1:0] out_q, out_d;
  logic [NIN-1:0]  edge_q, edge_d;
  logic [NIN-1:0]  irqen_q, irqen_d;
  logic [NIN-1:0]  in_w, rise_w, w1c;
  logic [DW-1:0]   d;
  logic            access, wr;
  logic            unused_d;

  m_sync_edge #(
    .NIN        (NIN),
    .SYNCSTAGES (SYNCSTAGES)
  ) u_sync (
    .clk_i  (CLK_I),
    .rst_i  (RST_I),
    .pin_i  (pin_i),
    .in_o   (in_w),
    .rise_o (rise_w)
  );

  // ~ack_q forces a gap so a held strobe completes one access per pulse
  assign access   = CYC_I & STB_I & ~ack_q;
  assign wr       = access & WE_I;
  assign d        = DAT_I & lane_mask(SEL_I);
  assign unused_d = ^d;

  always_comb begin
    out_d   = out_q;
    irqen_d = irqen_q;
    w1c     = '0;
    if (wr) begin
      case (ADR_I)
        A_OUT:   out_d   = d[NOUT-1:0];
        A_SET:   out_d   = out_q | d[NOUT-1:0];
        A_CLR:   out_d   = out_q & ~d[NOUT-1:0];
        A_TGL:   out_d   = out_q ^ d[NOUT-1:0];
        A_EDGE:  w1c     = d[NIN-1:0];
        A_IRQEN: irqen_d = d[NIN-1:0];
        default: ;
      endcase
    end
    // a new rise in the same cycle as a clear keeps the flag set
    edge_d = (edge_q & ~w1c) | rise_w;
  end

  always_comb begin
    dat_d = dat_q;
    if (access) begin
      dat_d = '0;
      if (!WE_I) begin
        case (ADR_I)
          A_OUT, A_SET,
          A_CLR, A_TGL: dat_d[NOUT-1:0] = out_q;
          A_IN:         dat_d[NIN-1:0]  = in_w;
          A_EDGE:       dat_d[NIN-1:0]  = edge_q;
          A_IRQEN:      dat_d[NIN-1:0]  = irqen_q;
          default:      ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      out_q   <= OUTRESET;
      edge_q  <= '0;
      irqen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= access;
      dat_q   <= dat_d;
      out_q   <= out_d;
      edge_q  <= edge_d;
      irqen_q <= irqen_d;
      irq_q   <= |(edge_q & irqen_q);
    end
  end

  assign ACK_O = ack_q;
  assign DAT_O = dat_q;
  assign pin_o = out_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_m_wb_gpio.sv
// Self-checking bench for m_wb_gpio: bus tasks push expected read data
// into a queue that is popped and compared on every observed ACK.
module tb_m_wb_gpio;
  import m_wb_gpio_pkg::*;

  localparam int          NOUT = 16;
  localparam int          NIN  = 1;
  localparam int          SS   = 2;
  localparam logic [15:0] ORST = 16'h000A;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cyc = 1'b0;
  logic            stb = 1'b0;
  logic            we  = 1'b0;
  logic [2:0]      adr = '0;
  logic [3:0]      sel = '0;
  logic [31:0]     dati = '0;
  logic [31:0]     dato;
  logic            ack;
  logic [NIN-1:0]  pin = '0;
  logic [NOUT-1:0] pout;
  logic            irq;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic        irq_ack;

  always #5 clk = ~clk;

  m_wb_gpio #(
    .NOUT       (NOUT),
    .NIN        (NIN),
    .SYNCSTAGES (SS),
    .OUTRESET   (ORST)
  ) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .CYC_I (cyc),
    .STB_I (stb),
    .WE_I  (we),
    .ADR_I (adr),
    .SEL_I (sel),
    .DAT_I (dati),
    .DAT_O (dato),
    .ACK_O (ack),
    .pin_i (pin),
    .pin_o (pout),
    .irq_o (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // caller is at a negedge; the access edge is the next posedge
  task automatic wb(input string tag, input logic w,
                    input logic [2:0] a, input logic [3:0] s,
                    input logic [31:0] dv, input logic [31:0] rexp,
                    output logic irq_at_ack);
    bit got_ack;
    exp_q.push_back(w ? 32'h0 : rexp);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dati = dv;
    got_ack = 1'b0;
    irq_at_ack = 1'b0;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(negedge clk);
      if (ack) got_ack = 1'b1;
    end
    if (!got_ack) begin
      chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      irq_at_ack = irq;
      chk({tag, "_dat"}, dato, exp_q.pop_front());
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_pulse"}, {31'd0, ack}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic ia;
    rst = 1'b1;
    idle(2);
    chk("rst_pin", {16'd0, pout}, 32'h000A);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_dat", dato, 32'd0);
    rst = 1'b0;
    idle(1);

    wb("w_out5", 1, A_OUT, 4'hF, 32'h5, 0, ia);
    chk("out5", {16'd0, pout}, 32'h5);

    wb("w_out3", 1, A_OUT, 4'hF, 32'h3, 0, ia);
    wb("w_set", 1, A_SET, 4'hF, 32'h4, 0, ia);
    chk("set", {16'd0, pout}, 32'h7);
    wb("w_clr", 1, A_CLR, 4'hF, 32'h1, 0, ia);
    chk("clr", {16'd0, pout}, 32'h6);
    wb("w_tgl", 1, A_TGL, 4'hF, 32'hF, 0, ia);
    chk("tgl", {16'd0, pout}, 32'h9);
    wb("r_set", 0, A_SET, 4'hF, 0, 32'h9, ia);
    wb("r_out", 0, A_OUT, 4'hF, 0, 32'h9, ia);

    // pin rise -> EDGE at edge 3, irq at edge 4
    wb("w_ien1", 1, A_IRQEN, 4'hF, 32'h1, 0, ia);
    pin = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk($sformatf("irq_edge%0d", e), {31'd0, irq}, {31'd0, e == 4});
    end
    wb("r_in", 0, A_IN, 4'hF, 0, 32'h1, ia);
    wb("r_edge1", 0, A_EDGE, 4'hF, 0, 32'h1, ia);

    // clear on the same edge as a fresh rise: set wins
    pin = 1'b0;
    idle(5);
    pin = 1'b1;
    idle(2);
    wb("w_w1c_rise", 1, A_EDGE, 4'hF, 32'h1, 0, ia);
    wb("r_edge_kept", 0, A_EDGE, 4'hF, 0, 32'h1, ia);
    wb("w_w1c", 1, A_EDGE, 4'hF, 32'h1, 0, ia);
    chk("irq_lag_hi", {31'd0, ia}, 32'd1);
    chk("irq_lag_lo", {31'd0, irq}, 32'd0);
    wb("r_edge0", 0, A_EDGE, 4'hF, 0, 32'h0, ia);

    // masked interrupt
    wb("w_ien0", 1, A_IRQEN, 4'hF, 32'h0, 0, ia);
    pin = 1'b0;
    idle(5);
    pin = 1'b1;
    idle(6);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    wb("r_edge_m", 0, A_EDGE, 4'hF, 0, 32'h1, ia);
    wb("r_ien", 0, A_IRQEN, 4'hF, 0, 32'h0, ia);
    wb("w_w1c_m", 1, A_EDGE, 4'hF, 32'h1, 0, ia);

    // byte lanes, ignored writes, unmapped read
    wb("w_out0", 1, A_OUT, 4'hF, 32'h0, 0, ia);
    wb("w_beef", 1, A_OUT, 4'b0010, 32'hBEEF, 0, ia);
    chk("lane", {16'd0, pout}, 32'hBE00);
    wb("w_adr7", 1, 3'd7, 4'hF, 32'hFFFF, 0, ia);
    wb("w_in", 1, A_IN, 4'hF, 32'hFFFF, 0, ia);
    chk("ign_wr", {16'd0, pout}, 32'hBE00);
    wb("r_adr7", 0, 3'd7, 4'hF, 0, 32'h0, ia);
    wb("r_in2", 0, A_IN, 4'hF, 0, 32'h1, ia);

    // held strobe: ACK 1,0,1,0
    exp_q.push_back(32'hBE00);
    exp_q.push_back(32'hBE00);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_OUT; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("hold_ack%0d", i), {31'd0, ack}, {31'd0, i % 2 == 0});
      if (ack && exp_q.size() > 0) chk("hold_dat", dato, exp_q.pop_front());
    end
    cyc = 1'b0; stb = 1'b0;
    idle(1);

    // no cycle or no strobe: nothing happens
    cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = A_OUT; dati = 32'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nocyc_ack", {31'd0, ack}, 32'd0);
    end
    cyc = 1'b1; stb = 1'b0;
    idle(2);
    chk("nostb_ack", {31'd0, ack}, 32'd0);
    chk("nostb_pin", {16'd0, pout}, 32'hBE00);
    cyc = 1'b0; we = 1'b0;

    // reset during a write strobe aborts it
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_OUT; sel = 4'hF;
    dati = 32'h1234;
    #2 rst = 1'b1;
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_pin", {16'd0, pout}, 32'h000A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_ack", {31'd0, ack}, 32'd0);
    end
    wb("w_after", 1, A_OUT, 4'hF, 32'h77, 0, ia);
    chk("after_pin", {16'd0, pout}, 32'h77);
    // pin held high through reset flags exactly once
    idle(3);
    wb("r_edge_rel", 0, A_EDGE, 4'hF, 0, 32'h1, ia);
    wb("w_w1c_rel", 1, A_EDGE, 4'hF, 32'h1, 0, ia);
    idle(3);
    wb("r_edge_once", 0, A_EDGE, 4'hF, 0, 32'h0, ia);
    chk("irq_final", {31'd0, irq}, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
